// File: rtl/led_seq_ctrl.sv
// LED sequencer: steps three LEDs through rotate/blink/bounce patterns, fed by a one-deep command slot.
// Define LED_SEQ_BOUNCE_EN to give mode 3 the bounce pattern; without it mode 3 behaves as rotate-right.
module led_seq_ctrl #(
  parameter int DIV_WIDTH  = 25,
  parameter int DEF_PERIOD = 24_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  input  logic                 cmd_run,
  output logic [2:0]           led_out,
  output logic                 tick,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0]           MODE_RL      = 2'd1;
  localparam logic [1:0]           MODE_BLINK   = 2'd2;
`ifdef LED_SEQ_BOUNCE_EN
  localparam logic [1:0]           MODE_BOUNCE  = 2'd3;
`endif
  localparam logic [2:0]           LED_RESET    = 3'b011;
  localparam logic [DIV_WIDTH-1:0] PERIOD_RESET = DIV_WIDTH'(DEF_PERIOD);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE      = DIV_WIDTH'(1);

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           led_q, led_d;
  logic                 tick_q, tick_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [1:0]           pend_mode_q, pend_mode_d;
  logic [DIV_WIDTH-1:0] pend_period_q, pend_period_d;
  logic                 pend_run_q, pend_run_d;
  logic                 at_wrap;
  logic                 apply;
`ifdef LED_SEQ_BOUNCE_EN
  logic                 dir_left_q, dir_left_d;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 2'd0;
      period_q      <= PERIOD_RESET;
      div_q         <= '0;
      led_q         <= LED_RESET;
      tick_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_mode_q   <= 2'd0;
      pend_period_q <= '0;
      pend_run_q    <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_left_q    <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      period_q      <= period_d;
      div_q         <= div_d;
      led_q         <= led_d;
      tick_q        <= tick_d;
      pend_valid_q  <= pend_valid_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      pend_run_q    <= pend_run_d;
`ifdef LED_SEQ_BOUNCE_EN
      dir_left_q    <= dir_left_d;
`endif
    end
  end

  // A pending command in RUN waits for the divider wrap so the current step period is never cut short;
  // when it lands on a wrap it replaces that step entirely.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    period_d      = period_q;
    div_d         = div_q;
    led_d         = led_q;
    tick_d        = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    pend_run_d    = pend_run_q;
`ifdef LED_SEQ_BOUNCE_EN
    dir_left_d    = dir_left_q;
`endif
    at_wrap = (div_q == period_q);
    apply   = pend_valid_q && ((state_q != ST_RUN) || at_wrap);

    if (cmd_valid && !pend_valid_q) begin
      pend_valid_d  = 1'b1;
      pend_mode_d   = cmd_mode;
      pend_period_d = cmd_period;
      pend_run_d    = cmd_run;
    end

    if (apply) begin
      pend_valid_d = 1'b0;
      mode_d       = pend_mode_q;
      period_d     = pend_period_q;
      div_d        = '0;
      state_d      = pend_run_q ? ST_RUN : ST_PAUSE;
`ifdef LED_SEQ_BOUNCE_EN
      dir_left_d   = 1'b1;
`endif
      case (pend_mode_q)
        MODE_BLINK:  led_d = 3'b000;
`ifdef LED_SEQ_BOUNCE_EN
        MODE_BOUNCE: led_d = 3'b001;
`endif
        default:     led_d = LED_RESET;
      endcase
    end else begin
      case (state_q)
        ST_RUN: begin
          if (at_wrap) begin
            div_d  = '0;
            tick_d = 1'b1;
            case (mode_q)
              MODE_RL:    led_d = {led_q[1:0], led_q[2]};
              MODE_BLINK: led_d = ~led_q;
`ifdef LED_SEQ_BOUNCE_EN
              // Turn around at an end by stepping inward, so the end value is shown only once.
              MODE_BOUNCE: begin
                if (dir_left_q) begin
                  if (led_q == 3'b100) begin
                    led_d      = 3'b010;
                    dir_left_d = 1'b0;
                  end else begin
                    led_d = {led_q[1:0], 1'b0};
                  end
                end else begin
                  if (led_q == 3'b001) begin
                    led_d      = 3'b010;
                    dir_left_d = 1'b1;
                  end else begin
                    led_d = {1'b0, led_q[2:1]};
                  end
                end
              end
`endif
              default:    led_d = {led_q[0], led_q[2:1]};
            endcase
          end else begin
            div_d = div_q + DIV_ONE;
          end
        end
        ST_PAUSE: begin
        end
        default: begin
          led_d = LED_RESET;
          div_d = '0;
        end
      endcase
    end
  end

  assign cmd_ready = !pend_valid_q;
  assign led_out   = led_q;
  assign tick      = tick_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: commands are planned ahead, expected apply/step events are queued,
// and a negedge monitor checks them. Honours LED_SEQ_BOUNCE_EN the same way the design does.
module tb_led_seq_ctrl;

  localparam int DIV_W = 25;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_period;
  logic             cmd_run;
  logic [2:0]       led_out;
  logic             tick;
  logic [1:0]       state_out;

  typedef struct {
    int         edge_at;
    logic [2:0] led;
    logic       tk;
    logic [1:0] st;
  } item_t;

  item_t sb[$];
  item_t mon_item;
  int    edge_n = 0;
  int    next_a = 0;
  int    tests  = 0;
  int    fails  = 0;

  led_seq_ctrl #(.DIV_WIDTH(DIV_W)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_period(cmd_period),
    .cmd_run   (cmd_run),
    .led_out   (led_out),
    .tick      (tick),
    .state_out (state_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) edge_n <= edge_n + 1;

  // k-th LED value of a pattern after its seed (k = 0 is the seed), taken straight from the pattern tables.
  function automatic logic [2:0] expLed(input logic [1:0] mode, input int k);
    int m;
    m = int'(mode);
`ifndef LED_SEQ_BOUNCE_EN
    if (m == 3) m = 0;
`endif
    case (m)
      0: case (k % 3) 0: return 3'b011; 1: return 3'b101; default: return 3'b110; endcase
      1: case (k % 3) 0: return 3'b011; 1: return 3'b110; default: return 3'b101; endcase
      2: return ((k % 2) == 0) ? 3'b000 : 3'b111;
      default: case (k % 4) 0: return 3'b001; 1: return 3'b010; 2: return 3'b100; default: return 3'b010; endcase
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [2:0] e_led, input logic [1:0] e_st,
                             input logic e_rdy, input logic e_tick);
    tests++;
    if (led_out !== e_led || state_out !== e_st || cmd_ready !== e_rdy || tick !== e_tick) begin
      fails++;
      $display("[TB] FAIL %s: got led=%b state=%0d ready=%b tick=%b, want led=%b state=%0d ready=%b tick=%b",
               name, led_out, state_out, cmd_ready, tick, e_led, e_st, e_rdy, e_tick);
    end
  endtask

  task automatic checkReady(input string name, input logic e_rdy);
    tests++;
    if (cmd_ready !== e_rdy) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got cmd_ready=%b, want %b", name, edge_n, cmd_ready, e_rdy);
    end
  endtask

  // Called at the negedge before the capture edge. The command applies at next_a; the following command
  // will be captured gap+1 edges after that, which fixes where this command's steps stop.
  task automatic applyStimulus(input logic [1:0] mode, input int period, input bit run, input int gap);
    int a, c_next, a_next;
    item_t it;
    a      = next_a;
    c_next = a + 1 + gap;
    if (run) begin
      a_next = a + period + 1;
      while (a_next < c_next + 1) a_next += period + 1;
    end else begin
      a_next = c_next + 1;
    end
    it.edge_at = a; it.led = expLed(mode, 0); it.tk = 1'b0; it.st = run ? 2'd1 : 2'd2;
    sb.push_back(it);
    if (run) begin
      for (int k = 1; a + k * (period + 1) < a_next; k++) begin
        it.edge_at = a + k * (period + 1); it.led = expLed(mode, k); it.tk = 1'b1; it.st = 2'd1;
        sb.push_back(it);
      end
    end
    next_a = a_next;
    checkReady("ready_before_cmd", 1'b1);
    cmd_valid  = 1'b1;
    cmd_mode   = mode;
    cmd_period = DIV_W'(period);
    cmd_run    = run;
    @(posedge clk_in);
    #1;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'($urandom);
    cmd_period = DIV_W'($urandom);
    cmd_run    = 1'($urandom);
    @(negedge clk_in);
    checkReady("ready_while_pending", 1'b0);
    while (edge_n < c_next - 1) @(negedge clk_in);
  endtask

  // Monitor: every expected event is checked on its edge; any tick not in the queue is an error.
  always @(negedge clk_in) begin
    if (sb.size() > 0 && sb[0].edge_at == edge_n) begin
      mon_item = sb.pop_front();
      tests++;
      if (led_out !== mon_item.led || tick !== mon_item.tk || state_out !== mon_item.st) begin
        fails++;
        $display("[TB] FAIL sb_event at edge %0d: got led=%b tick=%b state=%0d, want led=%b tick=%b state=%0d",
                 edge_n, led_out, tick, state_out, mon_item.led, mon_item.tk, mon_item.st);
      end
    end else if (tick === 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected_tick at edge %0d: got tick=1 led=%b, want tick=0", edge_n, led_out);
    end
    if (sb.size() > 0 && sb[0].edge_at < edge_n) begin
      mon_item = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missed_event: expected event at edge %0d not seen, now edge %0d", mon_item.edge_at, edge_n);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'd0;
    cmd_period = '0;
    cmd_run    = 1'b0;
    repeat (3) @(negedge clk_in);
    checkOutput("reset_hold", 3'b011, 2'd0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (100) @(negedge clk_in);
    checkOutput("idle_100", 3'b011, 2'd0, 1'b1, 1'b0);

    next_a = edge_n + 2;
    applyStimulus(2'd0, 3, 1'b1, 14);
    applyStimulus(2'd1, 0, 1'b1, 5);
    applyStimulus(2'd0, 9, 1'b1, 1);
    applyStimulus(2'd2, 1, 1'b1, 6);
    applyStimulus(2'd3, 0, 1'b1, 8);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom_range(0, 6), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 12));
    end

    applyStimulus(2'd1, 20, 1'b1, 3);
    cmd_valid  = 1'b1;
    cmd_mode   = 2'd2;
    cmd_period = DIV_W'(4);
    cmd_run    = 1'b0;
    @(posedge clk_in);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk_in);
    checkReady("ready_pending_before_rst", 1'b0);
    @(negedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 3'b011, 2'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_in);
    checkOutput("reset_mid_pending", 3'b011, 2'd0, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk_in);
    checkOutput("after_reset_idle", 3'b011, 2'd0, 1'b1, 1'b0);

    next_a = edge_n + 2;
    applyStimulus(2'd3, 0, 1'b1, 7);
    applyStimulus(2'd0, 2, 1'b0, 10);
    repeat (5) @(negedge clk_in);
    checkOutput("pause_frozen", 3'b011, 2'd2, 1'b1, 1'b0);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL sb_drained: got %0d events left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
